// File: rtl/vout_pkg.sv
// Shared definitions for the AXI4-Stream to video-timing retimer: sync states,
// FIFO entry layout helpers and the status counter width.
package vout_pkg;

    // Stream/timing alignment states
    typedef enum logic [1:0] {
        ST_SEEK    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_RUN     = 2'd2
    } vout_state_e;

    localparam int unsigned CNT_WIDTH = 16;

    // FIFO entry = {tlast, tuser, tdata}
    function automatic int unsigned entry_width(input int unsigned data_width);
        return data_width + 2;
    endfunction

    function automatic int unsigned tuser_pos(input int unsigned data_width);
        return data_width;
    endfunction

    function automatic int unsigned tlast_pos(input int unsigned data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/vout_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module vout_fifo_fwft #(
    parameter int unsigned WIDTH     = 26,
    parameter int unsigned PTR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   level
);

    localparam int unsigned Depth = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] PtrOne = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0]   mem_q [Depth];
    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;

    // Pointer advance; callers never push when full nor pop when empty
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    end

    // Pointer state
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage, no reset needed since contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                   (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/vout_axi4s_sync.sv
// Buffered AXI4-Stream to video-timing retimer. Pixels are queued in an elastic
// FIFO and released on in_de, aligned so that the tuser pixel lands on the first
// active pixel of each video frame. Drift between stream and timing forces a
// resync. Define VOUT_AXI4S_STATUS_EN to build the saturating status counters.
module vout_axi4s_sync
    import vout_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH     = 24,
    parameter int unsigned            CTL_WIDTH      = 4,
    parameter int unsigned            FIFO_PTR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0]  FILL_DATA      = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axi4s_tuser,
    input  logic                  s_axi4s_tlast,
    input  logic [DATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                  s_axi4s_tvalid,
    output logic                  s_axi4s_tready,
    input  logic                  in_vsync,
    input  logic                  in_hsync,
    input  logic                  in_de,
    input  logic [CTL_WIDTH-1:0]  in_ctl,
    output logic                  out_vsync,
    output logic                  out_hsync,
    output logic                  out_de,
    output logic [CTL_WIDTH-1:0]  out_ctl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_locked,
    output logic                  out_underflow,
    output logic                  out_resync,
    output logic [CNT_WIDTH-1:0]  out_underflow_count,
    output logic [CNT_WIDTH-1:0]  out_resync_count
);

    localparam int unsigned EntryWidth = entry_width(DATA_WIDTH);
    localparam int unsigned TuserPos   = tuser_pos(DATA_WIDTH);
    localparam int unsigned TlastPos   = tlast_pos(DATA_WIDTH);
    localparam logic [FIFO_PTR_WIDTH:0] LvlAlmost = {1'b0, {FIFO_PTR_WIDTH{1'b1}}};

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EntryWidth-1:0]  fifo_wdata, fifo_head;
    logic [FIFO_PTR_WIDTH:0] fifo_level;
    logic                   head_tuser;
    logic [DATA_WIDTH-1:0]  head_data;
    logic                   unused_tlast;

    vout_state_e            state_q, state_d;
    logic                   tready_q, tready_d;
    logic                   vsync_q;
    logic                   armed_q, armed_d;
    logic                   vchg, vfs;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   uf_q, uf_d, rs_q, rs_d;
    logic                   locked_q;
    logic                   vs_o_q, hs_o_q, de_o_q;
    logic [CTL_WIDTH-1:0]   ctl_o_q;

    assign fifo_push  = s_axi4s_tvalid & tready_q;
    assign fifo_wdata = {s_axi4s_tlast, s_axi4s_tuser, s_axi4s_tdata};

    vout_fifo_fwft #(
        .WIDTH     (EntryWidth),
        .PTR_WIDTH (FIFO_PTR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head_tuser   = fifo_head[TuserPos];
    assign head_data    = fifo_head[DATA_WIDTH-1:0];
    // tlast is carried through the FIFO but line length is not checked
    assign unused_tlast = fifo_head[TlastPos];

    // Frame start detection: a vsync edge arms, the next clean in_de fires
    always_comb begin
        vchg    = in_vsync ^ vsync_q;
        vfs     = in_de & armed_q & ~vchg;
        armed_d = armed_q;
        if (vchg) begin
            armed_d = 1'b1;
        end else if (in_de && armed_q) begin
            armed_d = 1'b0;
        end
    end

    // Alignment FSM next state, pop decision and pixel selection
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        data_d   = FILL_DATA;
        uf_d     = 1'b0;
        rs_d     = 1'b0;
        unique case (state_q)
            ST_SEEK: begin
                // Drain stale pixels until a frame start sits at the head
                if (!fifo_empty) begin
                    if (head_tuser) begin
                        state_d = ST_WAIT_FS;
                    end else begin
                        fifo_pop = 1'b1;
                    end
                end
            end
            ST_WAIT_FS: begin
                if (vfs && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = head_data;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_de) begin
                    if (fifo_empty) begin
                        uf_d = 1'b1;
                    end else if (vfs && !head_tuser) begin
                        // Stream behind timing: discard the rest of the old frame
                        rs_d    = 1'b1;
                        state_d = ST_SEEK;
                    end else if (!vfs && head_tuser) begin
                        // Stream ahead of timing: hold the new frame for next vfs
                        rs_d    = 1'b1;
                        state_d = ST_WAIT_FS;
                    end else begin
                        fifo_pop = 1'b1;
                        data_d   = head_data;
                    end
                end
            end
            default: state_d = ST_SEEK;
        endcase
    end

    // tready reflects the fill level after this cycle's push/pop
    always_comb begin
        tready_d = ~((fifo_full & ~fifo_pop) |
                     ((fifo_level == LvlAlmost) & fifo_push & ~fifo_pop));
    end

    // Registered state and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SEEK;
            tready_q <= 1'b0;
            vsync_q  <= 1'b0;
            armed_q  <= 1'b0;
            data_q   <= '0;
            uf_q     <= 1'b0;
            rs_q     <= 1'b0;
            locked_q <= 1'b0;
            vs_o_q   <= 1'b0;
            hs_o_q   <= 1'b0;
            de_o_q   <= 1'b0;
            ctl_o_q  <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            vsync_q  <= in_vsync;
            armed_q  <= armed_d;
            data_q   <= data_d;
            uf_q     <= uf_d;
            rs_q     <= rs_d;
            locked_q <= (state_d == ST_RUN);
            vs_o_q   <= in_vsync;
            hs_o_q   <= in_hsync;
            de_o_q   <= in_de;
            ctl_o_q  <= in_ctl;
        end
    end

    assign s_axi4s_tready = tready_q;
    assign out_vsync      = vs_o_q;
    assign out_hsync      = hs_o_q;
    assign out_de         = de_o_q;
    assign out_ctl        = ctl_o_q;
    assign out_data       = data_q;
    assign out_locked     = locked_q;
    assign out_underflow  = uf_q;
    assign out_resync     = rs_q;

`ifdef VOUT_AXI4S_STATUS_EN
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] uf_cnt_q, uf_cnt_d, rs_cnt_q, rs_cnt_d;

    // Saturating event counters, stepped together with their pulses
    always_comb begin
        uf_cnt_d = (uf_d && (uf_cnt_q != '1)) ? uf_cnt_q + CntOne : uf_cnt_q;
        rs_cnt_d = (rs_d && (rs_cnt_q != '1)) ? rs_cnt_q + CntOne : rs_cnt_q;
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            uf_cnt_q <= '0;
            rs_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
            rs_cnt_q <= rs_cnt_d;
        end
    end

    assign out_underflow_count = uf_cnt_q;
    assign out_resync_count    = rs_cnt_q;
`else
    assign out_underflow_count = '0;
    assign out_resync_count    = '0;
`endif

endmodule

// File: tb/tb_vout_axi4s_sync.sv
// Directed bench for vout_axi4s_sync: lock, underflow, stream-ahead and
// stream-behind resync, FIFO full backpressure and mid-line reset.
module tb_vout_axi4s_sync;

    localparam logic [23:0] FILL = 24'hF00F00;
`ifdef VOUT_AXI4S_STATUS_EN
    localparam bit StatEn = 1'b1;
`else
    localparam bit StatEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tuser, tlast, tvalid, tready;
    logic [23:0] tdata;
    logic        vs, hs, de;
    logic [3:0]  ctl;
    logic        out_vsync, out_hsync, out_de, out_locked, out_underflow, out_resync;
    logic [3:0]  out_ctl;
    logic [23:0] out_data;
    logic [15:0] out_underflow_count, out_resync_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vout_axi4s_sync #(
        .DATA_WIDTH     (24),
        .CTL_WIDTH      (4),
        .FIFO_PTR_WIDTH (4),
        .FILL_DATA      (FILL)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axi4s_tuser       (tuser),
        .s_axi4s_tlast       (tlast),
        .s_axi4s_tdata       (tdata),
        .s_axi4s_tvalid      (tvalid),
        .s_axi4s_tready      (tready),
        .in_vsync            (vs),
        .in_hsync            (hs),
        .in_de               (de),
        .in_ctl              (ctl),
        .out_vsync           (out_vsync),
        .out_hsync           (out_hsync),
        .out_de              (out_de),
        .out_ctl             (out_ctl),
        .out_data            (out_data),
        .out_locked          (out_locked),
        .out_underflow       (out_underflow),
        .out_resync          (out_resync),
        .out_underflow_count (out_underflow_count),
        .out_resync_count    (out_resync_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] d, input logic u, input logic l);
        tvalid = 1'b1; tdata = d; tuser = u; tlast = l; de = 1'b0;
        cyc();
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    endtask

    task automatic vtoggle();
        vs = ~vs; de = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = '0;
        vs = 1'b0; hs = 1'b0; de = 1'b0; ctl = '0;
        cyc(); cyc();
        n_cmp++;
        if (out_data !== 24'd0 || tready !== 1'b0 || out_locked !== 1'b0 || out_de !== 1'b0 ||
            out_underflow_count !== 16'd0 || out_resync_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: data=%h tready=%b lock=%b de=%b, want 0 0 0 0",
                     out_data, tready, out_locked, out_de);
        end
        reset = 1'b0;
        cyc();
        n_cmp++;
        if (tready !== 1'b1 || out_data !== FILL) begin
            n_err++;
            $display("FAIL reset_release: tready=%b data=%h, want 1 %h", tready, out_data, FILL);
        end
    endtask

    task automatic test_basic_frame();
        for (int i = 0; i < 8; i++) push(24'(i), (i == 0), (i % 4 == 3));
        vtoggle();
        n_cmp++;
        if (out_vsync !== vs) begin
            n_err++;
            $display("FAIL basic_vsync: got %b want %b", out_vsync, vs);
        end
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 4; i++) begin
                de = 1'b1;
                cyc();
                n_cmp++;
                if (out_data !== 24'(ln * 4 + i) || out_de !== 1'b1 || out_locked !== 1'b1 ||
                    out_underflow !== 1'b0 || out_resync !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_px%0d: data=%h de=%b lock=%b uf=%b rs=%b, want %h 1 1 0 0",
                             ln * 4 + i, out_data, out_de, out_locked, out_underflow, out_resync,
                             24'(ln * 4 + i));
                end
            end
            de = 1'b0; hs = 1'b1; ctl = 4'h5;
            cyc();
            hs = 1'b0; ctl = 4'h0;
            n_cmp++;
            if (out_hsync !== 1'b1 || out_ctl !== 4'h5 || out_de !== 1'b0 || out_data !== FILL) begin
                n_err++;
                $display("FAIL basic_blank%0d: hs=%b ctl=%h de=%b data=%h, want 1 5 0 %h",
                         ln, out_hsync, out_ctl, out_de, out_data, FILL);
            end
        end
    endtask

    task automatic test_underflow();
        logic [23:0] ed [4];
        logic        eu [4];
        ed = '{24'd10, 24'd11, FILL, FILL};
        eu = '{1'b0, 1'b0, 1'b1, 1'b1};
        push(24'd10, 1'b1, 1'b0);
        push(24'd11, 1'b0, 1'b0);
        vtoggle();
        for (int i = 0; i < 4; i++) begin
            de = 1'b1;
            cyc();
            n_cmp++;
            if (out_data !== ed[i] || out_underflow !== eu[i] || out_locked !== 1'b1 ||
                out_resync !== 1'b0) begin
                n_err++;
                $display("FAIL underflow_px%0d: data=%h uf=%b lock=%b rs=%b, want %h %b 1 0",
                         i, out_data, out_underflow, out_locked, out_resync, ed[i], eu[i]);
            end
        end
        de = 1'b0;
        cyc();
        n_cmp++;
        if (out_underflow_count !== (StatEn ? 16'd2 : 16'd0)) begin
            n_err++;
            $display("FAIL underflow_count: got %0d want %0d", out_underflow_count,
                     (StatEn ? 2 : 0));
        end
    endtask

    task automatic test_stream_ahead();
        logic [23:0] ed [4];
        logic        er [4];
        logic        el [4];
        ed = '{24'd20, 24'd21, FILL, FILL};
        er = '{1'b0, 1'b0, 1'b1, 1'b0};
        el = '{1'b1, 1'b1, 1'b0, 1'b0};
        push(24'd20, 1'b0, 1'b0);
        push(24'd21, 1'b0, 1'b0);
        push(24'd22, 1'b1, 1'b0);
        push(24'd23, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            de = 1'b1;
            cyc();
            n_cmp++;
            if (out_data !== ed[i] || out_resync !== er[i] || out_locked !== el[i] ||
                out_underflow !== 1'b0) begin
                n_err++;
                $display("FAIL ahead_px%0d: data=%h rs=%b lock=%b uf=%b, want %h %b %b 0",
                         i, out_data, out_resync, out_locked, out_underflow, ed[i], er[i], el[i]);
            end
        end
        de = 1'b0;
        cyc();
        vtoggle();
        for (int i = 0; i < 2; i++) begin
            de = 1'b1;
            cyc();
            n_cmp++;
            if (out_data !== 24'(22 + i) || out_locked !== 1'b1 || out_resync !== 1'b0) begin
                n_err++;
                $display("FAIL ahead_relock%0d: data=%h lock=%b rs=%b, want %h 1 0",
                         i, out_data, out_locked, out_resync, 24'(22 + i));
            end
        end
        de = 1'b0;
        cyc();
        n_cmp++;
        if (out_resync_count !== (StatEn ? 16'd1 : 16'd0)) begin
            n_err++;
            $display("FAIL ahead_count: got %0d want %0d", out_resync_count, (StatEn ? 1 : 0));
        end
    endtask

    task automatic test_stream_behind();
        logic er [4];
        er = '{1'b1, 1'b0, 1'b0, 1'b0};
        push(24'd30, 1'b0, 1'b0);
        push(24'd31, 1'b0, 1'b0);
        push(24'd32, 1'b0, 1'b0);
        push(24'd40, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) push(24'(40 + i), 1'b0, (i == 3));
        vtoggle();
        for (int i = 0; i < 4; i++) begin
            de = 1'b1;
            cyc();
            n_cmp++;
            if (out_data !== FILL || out_resync !== er[i] || out_locked !== 1'b0 ||
                out_underflow !== 1'b0) begin
                n_err++;
                $display("FAIL behind_px%0d: data=%h rs=%b lock=%b uf=%b, want %h %b 0 0",
                         i, out_data, out_resync, out_locked, out_underflow, FILL, er[i]);
            end
        end
        de = 1'b0;
        cyc(); cyc();
        vtoggle();
        for (int i = 0; i < 4; i++) begin
            de = 1'b1;
            cyc();
            n_cmp++;
            if (out_data !== 24'(40 + i) || out_locked !== 1'b1 || out_resync !== 1'b0) begin
                n_err++;
                $display("FAIL behind_next%0d: data=%h lock=%b rs=%b, want %h 1 0",
                         i, out_data, out_locked, out_resync, 24'(40 + i));
            end
        end
        de = 1'b0;
        cyc();
        n_cmp++;
        if (out_resync_count !== (StatEn ? 16'd2 : 16'd0)) begin
            n_err++;
            $display("FAIL behind_count: got %0d want %0d", out_resync_count, (StatEn ? 2 : 0));
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                n_cmp++;
                if (tready !== 1'b1) begin
                    n_err++;
                    $display("FAIL full_lvl15_tready: got %b want 1", tready);
                end
            end
            push(24'(50 + i), (i == 0), 1'b0);
        end
        n_cmp++;
        if (tready !== 1'b0) begin
            n_err++;
            $display("FAIL full_lvl16_tready: got %b want 0", tready);
        end
        // Offer one more word while full; it must be refused
        tvalid = 1'b1; tdata = 24'd99; de = 1'b0;
        cyc();
        tvalid = 1'b0;
        n_cmp++;
        if (tready !== 1'b0) begin
            n_err++;
            $display("FAIL full_hold_tready: got %b want 0", tready);
        end
        vtoggle();
        de = 1'b1;
        cyc();
        n_cmp++;
        if (out_data !== 24'd50 || tready !== 1'b1 || out_locked !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop: data=%h tready=%b lock=%b, want 000032 1 1",
                     out_data, tready, out_locked);
        end
        for (int i = 1; i < 16; i++) begin
            cyc();
            n_cmp++;
            if (out_data !== 24'(50 + i) || out_underflow !== 1'b0) begin
                n_err++;
                $display("FAIL full_drain%0d: data=%h uf=%b, want %h 0",
                         i, out_data, out_underflow, 24'(50 + i));
            end
        end
        cyc();
        n_cmp++;
        if (out_data !== FILL || out_underflow !== 1'b1) begin
            n_err++;
            $display("FAIL full_extra: data=%h uf=%b, want %h 1", out_data, out_underflow, FILL);
        end
        de = 1'b0;
        cyc();
        n_cmp++;
        if (out_underflow_count !== (StatEn ? 16'd3 : 16'd0)) begin
            n_err++;
            $display("FAIL full_uf_count: got %0d want %0d", out_underflow_count,
                     (StatEn ? 3 : 0));
        end
    endtask

    task automatic test_reset_mid_line();
        push(24'd70, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) push(24'(70 + i), 1'b0, 1'b0);
        vtoggle();
        de = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (out_data !== 24'd71 || out_locked !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre: data=%h lock=%b, want 000047 1", out_data, out_locked);
        end
        reset = 1'b1; vs = ~vs; hs = 1'b1; ctl = 4'hF; tvalid = 1'b1; tdata = 24'd99;
        cyc();
        n_cmp++;
        if (out_vsync !== 1'b0 || out_hsync !== 1'b0 || out_de !== 1'b0 || out_ctl !== 4'h0 ||
            out_data !== 24'd0 || out_locked !== 1'b0 || out_underflow !== 1'b0 ||
            out_resync !== 1'b0 || tready !== 1'b0 || out_underflow_count !== 16'd0 ||
            out_resync_count !== 16'd0) begin
            n_err++;
            $display("FAIL rst_outputs: vs=%b hs=%b de=%b ctl=%h data=%h lock=%b tready=%b, want all 0",
                     out_vsync, out_hsync, out_de, out_ctl, out_data, out_locked, tready);
        end
        cyc();
        reset = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0; ctl = 4'h0; tvalid = 1'b0;
        cyc();
        n_cmp++;
        if (tready !== 1'b1 || out_locked !== 1'b0 || out_data !== FILL) begin
            n_err++;
            $display("FAIL rst_release: tready=%b lock=%b data=%h, want 1 0 %h",
                     tready, out_locked, out_data, FILL);
        end
        push(24'd80, 1'b1, 1'b0);
        push(24'd81, 1'b0, 1'b0);
        vtoggle();
        for (int i = 0; i < 2; i++) begin
            de = 1'b1;
            cyc();
            n_cmp++;
            if (out_data !== 24'(80 + i) || out_locked !== 1'b1 || out_resync !== 1'b0) begin
                n_err++;
                $display("FAIL rst_relock%0d: data=%h lock=%b rs=%b, want %h 1 0",
                         i, out_data, out_locked, out_resync, 24'(80 + i));
            end
        end
        de = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underflow();
        test_stream_ahead();
        test_stream_behind();
        test_fifo_full();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
